// File: rtl/trng_vn_packer.sv
// trng_vn_packer
//   Post-processing for the RS-latch entropy cell. Raw bits are synchronised
//   into clk and sampled every SAMPLE_DIV cycles while en=1. A von Neumann
//   extractor removes bias. Debiased bits are packed MSB-first into bytes and
//   handed out over valid/ready. A sticky repetition-count health test blocks
//   all output while the source appears stuck.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   en           sampling enable; dropping it discards any partial byte/pair
//   raw_bit      entropy bit, asynchronous to clk
//   byte_ready   consumer accepts byte_out
//   fail_clr     one-cycle pulse, clears health_fail
//   byte_out     assembled byte, stable while byte_valid && !byte_ready
//   byte_valid   byte_out holds an unconsumed byte
//   health_fail  sticky repetition-count failure
module trng_vn_packer #(
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       raw_bit,
    input  logic       byte_ready,
    input  logic       fail_clr,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);

    logic [1:0]       sync_q;
    logic [DIV_W-1:0] div_cnt;
    logic             have_a;
    logic             a_bit;
    logic [7:0]       shreg;
    logic [3:0]       bit_cnt;
    logic [RUN_W-1:0] run;
    logic             last_bit;
    logic             have_last;  // cleared by reset/fail_clr so the next strobe starts a fresh run

    logic             s_bit;
    logic             strobe;
    logic [RUN_W-1:0] run_nxt;
    logic             trip;
    logic             kill;
    logic             emit;
    logic             shift_ok;
    logic [7:0]       shreg_nxt;
    logic [3:0]       cnt_nxt;
    logic             free;
    logic             xfer;
    logic             load;

    always_comb begin
        s_bit  = sync_q[1];
        strobe = en && (div_cnt == DIV_LAST);

        run_nxt = RUN_W'(1);
        if (have_last && (s_bit == last_bit))
            run_nxt = (run == RUN_MAX) ? run : run + RUN_W'(1);

        // fail_clr beats a trip landing on the same edge
        trip = strobe && !fail_clr && (run_nxt == RUN_MAX);
        // covers the trip edge too, so byte_valid and health_fail change together
        kill = health_fail || trip;

        // only unequal pairs emit, and the emitted bit is always the first of the pair
        emit = strobe && !health_fail && have_a && (a_bit != s_bit);

        // a full shreg (bit_cnt==8) waiting on the holding register drops new bits
        shift_ok  = emit && (bit_cnt != 4'd8);
        shreg_nxt = shift_ok ? {shreg[6:0], a_bit} : shreg;
        cnt_nxt   = shift_ok ? bit_cnt + 4'd1 : bit_cnt;

        xfer = byte_valid && byte_ready;
        free = !byte_valid || byte_ready;
        load = en && (cnt_nxt == 4'd8) && free;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            div_cnt     <= '0;
            have_a      <= 1'b0;
            a_bit       <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            run         <= '0;
            last_bit    <= 1'b0;
            have_last   <= 1'b0;
            health_fail <= 1'b0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_bit};

            if (!en || strobe) div_cnt <= '0;
            else               div_cnt <= div_cnt + DIV_W'(1);

            // repetition count runs on every strobe, even while failed
            if (fail_clr) begin
                health_fail <= 1'b0;
                run         <= '0;
                have_last   <= 1'b0;
            end else if (strobe) begin
                run       <= run_nxt;
                last_bit  <= s_bit;
                have_last <= 1'b1;
                if (run_nxt == RUN_MAX) health_fail <= 1'b1;
            end

            // extractor + packer
            if (kill || !en) begin
                have_a  <= 1'b0;
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                if (strobe) begin
                    if (have_a) begin
                        have_a <= 1'b0;
                    end else begin
                        have_a <= 1'b1;
                        a_bit  <= s_bit;
                    end
                end
                shreg   <= shreg_nxt;
                bit_cnt <= load ? 4'd0 : cnt_nxt;
            end

            // holding register; a load on a transfer edge keeps valid high
            if (kill) begin
                byte_valid <= 1'b0;
            end else if (load) begin
                byte_out   <= shreg_nxt;
                byte_valid <= 1'b1;
            end else if (xfer) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trng_vn_packer.sv
// Directed bench for trng_vn_packer with SAMPLE_DIV=1, REP_LIMIT=32.
// Raw streams are fed one bit per cycle; en is raised two cycles after the
// first bit so the first strobe sees the first stream bit through the
// synchroniser, and pairs line up with the stream.
module tb_trng_vn_packer;

    logic       clk = 1'b0;
    logic       rst_n, en, raw_bit, byte_ready, fail_clr;
    logic [7:0] byte_out;
    logic       byte_valid, health_fail;

    always #5 clk = ~clk;

    trng_vn_packer #(.SAMPLE_DIV(1), .REP_LIMIT(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit),
        .byte_ready(byte_ready), .fail_clr(fail_clr), .byte_out(byte_out),
        .byte_valid(byte_valid), .health_fail(health_fail)
    );

    int tests = 0;
    int fails = 0;

    // monitor: accepted bytes, valid cycles, hold-stability violations
    logic [7:0] got[$];
    int         vcycles = 0;
    int         stable_err = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_out = '0;

    always begin
        @(negedge clk);
        #1;
        if (rst_n === 1'b1) begin
            if (byte_valid) vcycles++;
            if (byte_valid && byte_ready) got.push_back(byte_out);
            if (prev_hold && byte_valid && byte_out !== prev_out) stable_err++;
        end
        prev_hold = (rst_n === 1'b1) && byte_valid && !byte_ready;
        prev_out  = byte_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // feed s[n-1] first; exactly n strobes see the stream. keep=1 leaves en
    // high with raw_bit held at the last stream bit.
    task automatic play(input logic [63:0] s, input int n, input bit keep);
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            raw_bit = (i < n) ? s[n-1-i] : s[0];
            en      = (i >= 2);
        end
        if (!keep) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] stream;
        int          len;
        int          nbytes;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int gb;
        int vb;

        vecs[0] = '{"basic_a5",   64'(16'b10_01_10_01_01_10_01_10), 16, 1, 8'hA5};
        vecs[1] = '{"discard_a5", 64'(24'b10_00_01_11_10_01_00_01_10_11_01_10), 24, 1, 8'hA5};
        vecs[2] = '{"all_zero",   64'(16'h5555), 16, 1, 8'h00};
        vecs[3] = '{"all_one",    64'(16'hAAAA), 16, 1, 8'hFF};
        vecs[4] = '{"byte_3c",    64'(16'b01_01_10_10_10_10_01_01), 16, 1, 8'h3C};
        vecs[5] = '{"six_bits",   64'(16'b10_10_10_10_10_10_00_00), 16, 0, 8'h00};

        // reset held with en=1 and raw_bit toggling
        rst_n = 1'b0; en = 1'b1; raw_bit = 1'b0; byte_ready = 1'b0; fail_clr = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset_cyc%0d", i), {byte_out, byte_valid, health_fail}, 32'h0);
            raw_bit = ~raw_bit;
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; byte_ready = 1'b1;
        idle(3);

        // table: one stream each, consumer always ready
        for (int k = 0; k < 6; k++) begin
            gb = got.size();
            vb = vcycles;
            play(vecs[k].stream, vecs[k].len, 1'b0);
            idle(3);
            check({vecs[k].name, "_count"}, got.size() - gb, vecs[k].nbytes);
            check({vecs[k].name, "_vcycles"}, vcycles - vb, vecs[k].nbytes);
            if (vecs[k].nbytes > 0 && got.size() > gb)
                check({vecs[k].name, "_byte"}, got[gb], vecs[k].exp);
        end

        // backpressure: 0x0F, 0xF0, then 8 bits that must be dropped
        byte_ready = 1'b0;
        gb = got.size();
        play(64'h55AA_AA55_5A5A, 48, 1'b1);
        idle(2);
        #1;
        check("bp_hold_valid", byte_valid, 1);
        check("bp_hold_byte", byte_out, 8'h0F);
        @(negedge clk);
        byte_ready = 1'b1;
        #1;
        check("bp_first_byte", byte_out, 8'h0F);
        @(negedge clk);
        #1;
        check("bp_second_valid", byte_valid, 1);
        check("bp_second_byte", byte_out, 8'hF0);
        @(negedge clk);
        #1;
        check("bp_drain_valid", byte_valid, 0);
        en = 1'b0;
        idle(2);
        check("bp_count", got.size() - gb, 2);
        if (got.size() >= gb + 2) begin
            check("bp_got0", got[gb], 8'h0F);
            check("bp_got1", got[gb+1], 8'hF0);
        end
        check("bp_stable", stable_err, 0);

        // en dropped after 5 bits plus half a pair, then a fresh 0x3C
        gb = got.size();
        play(64'(11'b10_10_01_10_01_1), 11, 1'b0);
        play(64'(16'b01_01_10_10_10_10_01_01), 16, 1'b0);
        idle(3);
        check("en_mid_count", got.size() - gb, 1);
        if (got.size() > gb) check("en_mid_byte", got[gb], 8'h3C);

        // health: pending 0xC3 (ends on a 0), then raw stuck at 1
        byte_ready = 1'b0;
        play(64'(16'b10_10_01_01_01_01_10_10), 16, 1'b0);
        @(negedge clk);
        raw_bit = 1'b1;
        idle(3);
        @(negedge clk);
        en = 1'b1;
        repeat (31) @(negedge clk);
        #1;
        check("hf_at_31", health_fail, 0);
        check("hf_pending_valid", byte_valid, 1);
        check("hf_pending_byte", byte_out, 8'hC3);
        @(negedge clk);
        #1;
        check("hf_at_32", health_fail, 1);
        check("hf_valid_dropped", byte_valid, 0);
        idle(4);
        #1;
        check("hf_sticky", {health_fail, byte_valid}, 2'b10);
        @(negedge clk);
        fail_clr = 1'b1; raw_bit = 1'b0; byte_ready = 1'b1;
        @(negedge clk);
        fail_clr = 1'b0; en = 1'b0;
        #1;
        check("hf_cleared", health_fail, 0);
        gb = got.size();
        play(64'(16'h6699), 16, 1'b0);
        idle(3);
        check("hf_resume_count", got.size() - gb, 1);
        if (got.size() > gb) check("hf_resume_byte", got[gb], 8'h5A);
        check("hf_still_clear", health_fail, 0);

        // reset with a byte pending
        byte_ready = 1'b0;
        play(64'(16'hAAAA), 16, 1'b0);
        idle(1);
        #1;
        check("rst_pending_valid", {byte_valid, byte_out}, 9'h1FF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_clear", {byte_valid, byte_out, health_fail}, 10'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
